// File: rtl/ternary_popcount_acc_pkg.sv
// Shared types and constants for the ternary popcount accumulator.
//   state_e   : FSM states (ACC = accepting beats, OUT = holding a result)
//   ACT_*     : encodings of the ternary activation on out_act
//   sum_width : width of the signed accumulator for a given lane count and beat limit
package tpc_pkg;

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } state_e;

    localparam logic [1:0] ACT_POS  = 2'b01;
    localparam logic [1:0] ACT_ZERO = 2'b00;
    localparam logic [1:0] ACT_NEG  = 2'b11;

    // Magnitude can reach width*beats in either direction, plus one sign bit.
    function automatic int sum_width(input int width, input int beats);
        return $clog2(width * beats + 1) + 1;
    endfunction

endpackage

// File: rtl/ternary_popcount_acc_popcount_tree.sv
// Combinational population count of a WIDTH-bit word.
//   bits  : in  WIDTH          operand
//   count : out CNT_W          number of ones in bits
// Written as a reduction loop; synthesis balances it into an adder tree.
// An approximate counter may replace this module behind the same ports.
module popcount_tree #(
    parameter int WIDTH = 24,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] bits,
    output logic [CNT_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + CNT_W'(bits[i]);
        end
    end

endmodule

// File: rtl/ternary_popcount_acc.sv
// Streaming ternary-neuron core. Each beat contributes
// popcount(in_pos & m) - popcount(in_neg & m) to a signed sum; the beat with
// in_last emits the total and a ternary activation derived from thr_hi/thr_lo.
//   clk, rst_n            : clock (rising edge), async active-low reset
//   approx_en             : drop low APPROX_DROP lanes; taken from the first beat
//   in_valid/in_ready     : input beat handshake
//   in_pos/in_neg/in_last : +1 lanes, -1 lanes, final beat marker
//   thr_hi/thr_lo         : signed thresholds, sampled with the last beat
//   out_valid/out_ready   : result handshake
//   out_sum/out_act/out_err : signed sum, activation (01/+1, 11/-1, 00/0), overflow flag
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready and out_valid are pure flop outputs, so neither depends
// combinationally on in_valid or out_ready. While out_valid && !out_ready the
// out_* values are held.
module ternary_popcount_acc
    import tpc_pkg::*;
#(
    parameter int WIDTH       = 24,
    parameter int MAX_BEATS   = 8,
    parameter int APPROX_DROP = 4,
    parameter int SUM_W       = sum_width(WIDTH, MAX_BEATS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             approx_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_pos,
    input  logic [WIDTH-1:0] in_neg,
    input  logic             in_last,
    input  logic [SUM_W-1:0] thr_hi,
    input  logic [SUM_W-1:0] thr_lo,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic [1:0]       out_act,
    output logic             out_err
);

    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam int BEAT_W = $clog2(MAX_BEATS + 1);
    localparam logic [WIDTH-1:0] APPROX_MASK = ~((WIDTH'(1) << APPROX_DROP) - WIDTH'(1));

    state_e                   state_q, state_d;
    logic signed [SUM_W-1:0]  acc_q, acc_d;
    logic [BEAT_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic                     first_q, first_d;
    logic                     approx_q, approx_d;
    logic                     err_q, err_d;
    logic                     in_ready_q, in_ready_d;
    logic [SUM_W-1:0]         out_sum_q, out_sum_d;
    logic [1:0]               out_act_q, out_act_d;
    logic                     out_err_q, out_err_d;

    logic                     approx_eff;
    logic [WIDTH-1:0]         lane_mask, pos_masked, neg_masked;
    logic [CNT_W-1:0]         pc_pos, pc_neg;
    logic signed [SUM_W-1:0]  beat_delta, beat_add, sum_total;
    logic                     fire, overflow, handshake;

    // The first beat uses the live approx_en; later beats use the latched copy.
    assign approx_eff = first_q ? approx_en : approx_q;
    assign lane_mask  = approx_eff ? APPROX_MASK : '1;
    assign pos_masked = in_pos & lane_mask;
    assign neg_masked = in_neg & lane_mask;

    popcount_tree #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_pc_pos (
        .bits  (pos_masked),
        .count (pc_pos)
    );

    popcount_tree #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_pc_neg (
        .bits  (neg_masked),
        .count (pc_neg)
    );

    assign beat_delta = $signed(SUM_W'(pc_pos)) - $signed(SUM_W'(pc_neg));
    assign fire       = in_valid && in_ready_q;
    assign overflow   = (beat_cnt_q == BEAT_W'(MAX_BEATS));
    // Beats past the limit are dropped, which also bounds the sum inside SUM_W.
    assign beat_add   = overflow ? '0 : beat_delta;
    assign sum_total  = acc_q + beat_add;
    assign handshake  = (state_q == OUT) && out_ready;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACC: if (fire && in_last) state_d = OUT;
            OUT: if (out_ready)       state_d = ACC;
            default:                  state_d = ACC;
        endcase
    end

    // Datapath next values
    always_comb begin
        acc_d      = acc_q;
        beat_cnt_d = beat_cnt_q;
        first_d    = first_q;
        approx_d   = approx_q;
        err_d      = err_q;
        out_sum_d  = out_sum_q;
        out_act_d  = out_act_q;
        out_err_d  = out_err_q;
        in_ready_d = (state_d == ACC);

        if (fire) begin
            if (in_last) begin
                out_sum_d = sum_total;
                // +1 is checked first so it wins when thr_lo >= thr_hi.
                if (sum_total >= $signed(thr_hi)) begin
                    out_act_d = ACT_POS;
                end else if (sum_total <= $signed(thr_lo)) begin
                    out_act_d = ACT_NEG;
                end else begin
                    out_act_d = ACT_ZERO;
                end
                out_err_d  = err_q | overflow;
                acc_d      = '0;
                beat_cnt_d = '0;
                err_d      = 1'b0;
                first_d    = 1'b1;
            end else begin
                acc_d      = sum_total;
                beat_cnt_d = overflow ? beat_cnt_q : beat_cnt_q + BEAT_W'(1);
                err_d      = err_q | overflow;
                first_d    = 1'b0;
                if (first_q) approx_d = approx_en;
            end
        end else if (handshake) begin
            out_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACC;
            acc_q      <= '0;
            beat_cnt_q <= '0;
            first_q    <= 1'b1;
            approx_q   <= 1'b0;
            err_q      <= 1'b0;
            in_ready_q <= 1'b0;
            out_sum_q  <= '0;
            out_act_q  <= ACT_ZERO;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            beat_cnt_q <= beat_cnt_d;
            first_q    <= first_d;
            approx_q   <= approx_d;
            err_q      <= err_d;
            in_ready_q <= in_ready_d;
            out_sum_q  <= out_sum_d;
            out_act_q  <= out_act_d;
            out_err_q  <= out_err_d;
        end
    end

    // Outputs
    always_comb begin
        in_ready  = in_ready_q;
        out_valid = (state_q == OUT);
        out_sum   = out_sum_q;
        out_act   = out_act_q;
        out_err   = out_err_q;
    end

endmodule

// File: tb/tb_ternary_popcount_acc.sv
module tb_ternary_popcount_acc;

    localparam int WIDTH       = 24;
    localparam int MAX_BEATS   = 8;
    localparam int APPROX_DROP = 4;
    localparam int SUM_W       = 9;
    localparam int TIMEOUT     = 100;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             approx_en;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_pos;
    logic [WIDTH-1:0] in_neg;
    logic             in_last;
    logic [SUM_W-1:0] thr_hi;
    logic [SUM_W-1:0] thr_lo;
    logic             out_valid;
    logic             out_ready;
    logic [SUM_W-1:0] out_sum;
    logic [1:0]       out_act;
    logic             out_err;

    ternary_popcount_acc #(
        .WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS), .APPROX_DROP(APPROX_DROP), .SUM_W(SUM_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .approx_en(approx_en),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pos(in_pos), .in_neg(in_neg), .in_last(in_last),
        .thr_hi(thr_hi), .thr_lo(thr_lo),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_act(out_act), .out_err(out_err)
    );

    int total = 0;
    int bad   = 0;

    // Current vector under construction
    logic [WIDTH-1:0] v_pos[$];
    logic [WIDTH-1:0] v_neg[$];
    logic             v_apx[$];

    // Scoreboard
    logic [SUM_W-1:0] exp_q[$];
    logic [1:0]       exp_act_q[$];
    logic             exp_err_q[$];

    // ---------------- reference model ----------------
    // Sum of (+1 lanes) - (-1 lanes) over the first MAX_BEATS beats, using the
    // first beat's mode for the whole vector; activation from the thresholds.
    function automatic void model_vector(input int thi, input int tlo);
        int               sum;
        logic [WIDTH-1:0] m;
        int               n;
        n   = v_pos.size();
        sum = 0;
        m   = '1;
        if (v_apx[0]) m = ~((WIDTH'(1) << APPROX_DROP) - WIDTH'(1));
        for (int k = 0; k < n && k < MAX_BEATS; k++) begin
            sum += $countones(v_pos[k] & m) - $countones(v_neg[k] & m);
        end
        exp_q.push_back(SUM_W'(sum));
        if (sum >= thi)      exp_act_q.push_back(2'b01);
        else if (sum <= tlo) exp_act_q.push_back(2'b11);
        else                 exp_act_q.push_back(2'b00);
        exp_err_q.push_back(n > MAX_BEATS);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_beat(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] n,
                             input logic last, input logic apx);
        int guard;
        guard     = 0;
        in_pos    = p;
        in_neg    = n;
        in_last   = last;
        approx_en = apx;
        in_valid  = 1'b1;
        while (in_ready !== 1'b1 && guard < TIMEOUT) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= TIMEOUT) begin
            total++; bad++;
            $display("FAIL in_ready_timeout: got in_ready=%b want 1 within %0d cycles", in_ready, TIMEOUT);
        end else begin
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        approx_en = 1'($urandom_range(0, 1));
    endtask

    // Sends the queued vector; samples outputs one cycle after the last beat fires.
    task automatic drive_vector(input int thi, input int tlo,
                                output logic v, output logic [SUM_W-1:0] s,
                                output logic [1:0] a, output logic e);
        int n;
        n      = v_pos.size();
        thr_hi = SUM_W'(thi);
        thr_lo = SUM_W'(tlo);
        model_vector(thi, tlo);
        for (int k = 0; k < n; k++) begin
            send_beat(v_pos[k], v_neg[k], (k == n - 1), v_apx[k]);
        end
        v = out_valid; s = out_sum; a = out_act; e = out_err;
        v_pos.delete(); v_neg.delete(); v_apx.delete();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic push_beat(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] n, input logic apx);
        v_pos.push_back(p); v_neg.push_back(n); v_apx.push_back(apx);
    endtask

    // ---------------- tests ----------------
    logic             ov, oe;
    logic [SUM_W-1:0] os, es;
    logic [1:0]       oa, ea;
    logic             ee;

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; approx_en = 1'b0;
        in_pos = '0; in_neg = '0; thr_hi = '0; thr_lo = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({in_ready, out_valid, out_sum, out_act, out_err} !== {1'b0, 1'b0, 9'd0, 2'b00, 1'b0}) begin
            bad++;
            $display("FAIL reset_init: got rdy=%b vld=%b sum=%0d act=%b err=%b want all 0",
                     in_ready, out_valid, out_sum, out_act, out_err);
        end
        rst_n = 1'b1;
        // three beats of a vector, then reset mid-vector
        for (int k = 0; k < 3; k++) send_beat(24'hFFFFFF, 24'h0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({in_ready, out_valid, out_sum, out_act, out_err} !== {1'b0, 1'b0, 9'd0, 2'b00, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid: got rdy=%b vld=%b sum=%0d act=%b err=%b want all 0",
                     in_ready, out_valid, out_sum, out_act, out_err);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        push_beat(24'h0000FF, 24'h0, 1'b0);
        drive_vector(100, -100, ov, os, oa, oe);
        es = exp_q.pop_front(); ea = exp_act_q.pop_front(); ee = exp_err_q.pop_front();
        total++;
        if ({ov, os, oa, oe} !== {1'b1, es, ea, ee}) begin
            bad++;
            $display("FAIL reset_fresh_sum: got vld=%b sum=%0d act=%b err=%b want 1 %0d %b %b",
                     ov, $signed(os), oa, oe, $signed(es), ea, ee);
        end
        drain();
    endtask

    task automatic test_single_beat();
        push_beat(24'hFFFFFF, 24'h0, 1'b0);
        drive_vector(10, -10, ov, os, oa, oe);
        es = exp_q.pop_front(); ea = exp_act_q.pop_front(); ee = exp_err_q.pop_front();
        total++;
        if ({ov, os, oa, oe} !== {1'b1, 9'd24, 2'b01, 1'b0} || os !== es) begin
            bad++;
            $display("FAIL single_beat: got vld=%b sum=%0d act=%b err=%b want 1 24 01 0", ov, os, oa, oe);
        end
        drain();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_drain: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_multi_beat();
        for (int k = 0; k < 3; k++) push_beat(24'h00000F, 24'h0000FF, 1'b0);
        drive_vector(5, -5, ov, os, oa, oe);
        es = exp_q.pop_front(); ea = exp_act_q.pop_front(); ee = exp_err_q.pop_front();
        total++;
        if ({ov, os, oa, oe} !== {1'b1, es, ea, ee} || $signed(os) !== -9'sd12 || oa !== 2'b11) begin
            bad++;
            $display("FAIL multi_beat: got vld=%b sum=%0d act=%b err=%b want 1 -12 11 0",
                     ov, $signed(os), oa, oe);
        end
        drain();
        // thr_lo >= thr_hi: +1 wins
        push_beat(24'h00000F, 24'h0, 1'b0);
        drive_vector(3, 10, ov, os, oa, oe);
        es = exp_q.pop_front(); ea = exp_act_q.pop_front(); ee = exp_err_q.pop_front();
        total++;
        if ({ov, os, oa, oe} !== {1'b1, es, ea, ee}) begin
            bad++;
            $display("FAIL thr_priority: got sum=%0d act=%b want %0d %b", os, oa, es, ea);
        end
        drain();
    endtask

    task automatic test_approx();
        push_beat(24'h0000FF, 24'h0, 1'b1);
        drive_vector(100, -100, ov, os, oa, oe);
        es = exp_q.pop_front(); ea = exp_act_q.pop_front(); ee = exp_err_q.pop_front();
        total++;
        if ({ov, os, oa, oe} !== {1'b1, es, ea, ee} || os !== 9'd4) begin
            bad++;
            $display("FAIL approx_single: got sum=%0d want 4", os);
        end
        drain();
        // mode toggled on beat 2 must be ignored: 4 + 4 = 8
        push_beat(24'h0000FF, 24'h0, 1'b1);
        push_beat(24'h0000FF, 24'h0, 1'b0);
        drive_vector(100, -100, ov, os, oa, oe);
        es = exp_q.pop_front(); ea = exp_act_q.pop_front(); ee = exp_err_q.pop_front();
        total++;
        if ({ov, os, oa, oe} !== {1'b1, es, ea, ee} || os !== 9'd8) begin
            bad++;
            $display("FAIL approx_hold: got sum=%0d want 8", os);
        end
        drain();
    endtask

    task automatic test_backpressure_overflow();
        for (int k = 0; k < 9; k++) push_beat(24'h000001, 24'h0, 1'b0);
        drive_vector(100, -100, ov, os, oa, oe);
        es = exp_q.pop_front(); ea = exp_act_q.pop_front(); ee = exp_err_q.pop_front();
        total++;
        if ({ov, os, oa, oe} !== {1'b1, es, ea, ee} || os !== 9'd8 || oe !== 1'b1) begin
            bad++;
            $display("FAIL overflow: got sum=%0d err=%b want 8 1", os, oe);
        end
        for (int h = 0; h < 5; h++) begin
            in_valid = 1'b1; in_pos = 24'hFFFFFF; in_last = 1'b1;
            @(posedge clk); #1;
            total++;
            if ({out_valid, out_sum, out_act, out_err, in_ready} !== {1'b1, es, ea, ee, 1'b0}) begin
                bad++;
                $display("FAIL backpressure_hold: cycle %0d got vld=%b sum=%0d act=%b err=%b rdy=%b want 1 %0d %b %b 0",
                         h, out_valid, out_sum, out_act, out_err, in_ready, es, ea, ee);
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
        drain();
        total++;
        if ({out_valid, out_err} !== 2'b00) begin
            bad++;
            $display("FAIL err_clear: got vld=%b err=%b want 0 0", out_valid, out_err);
        end
    endtask

    task automatic test_overlap();
        push_beat(24'hABCDEF, 24'hABCDEF, 1'b0);
        drive_vector(1, -1, ov, os, oa, oe);
        es = exp_q.pop_front(); ea = exp_act_q.pop_front(); ee = exp_err_q.pop_front();
        total++;
        if ({ov, os, oa, oe} !== {1'b1, es, ea, ee} || os !== 9'd0 || oa !== 2'b00) begin
            bad++;
            $display("FAIL overlap_zero: got sum=%0d act=%b want 0 00", os, oa);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int nb, thi, tlo;
        out_ready = 1'b1;
        for (int vec = 0; vec < 16; vec++) begin
            nb = $urandom_range(1, 10);
            for (int k = 0; k < nb; k++) begin
                push_beat(24'($urandom()), 24'($urandom()), 1'($urandom_range(0, 1)));
            end
            thi = $urandom_range(0, 60) - 30;
            tlo = $urandom_range(0, 60) - 30;
            drive_vector(thi, tlo, ov, os, oa, oe);
            es = exp_q.pop_front(); ea = exp_act_q.pop_front(); ee = exp_err_q.pop_front();
            total++;
            if ({ov, os, oa, oe} !== {1'b1, es, ea, ee}) begin
                bad++;
                $display("FAIL back_to_back[%0d]: got vld=%b sum=%0d act=%b err=%b want 1 %0d %b %b",
                         vec, ov, $signed(os), oa, oe, $signed(es), ea, ee);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_beat();
        test_multi_beat();
        test_approx();
        test_backpressure_overflow();
        test_overlap();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
